// File: rtl/i2so_pkg.sv
// i2so_pkg: mode and FSM state encodings shared by the I2S/TDM output serializer
package i2so_pkg;
  localparam logic [1:0] I2SO_MODE_I2S = 2'b00;
  localparam logic [1:0] I2SO_MODE_LJ  = 2'b01;
  localparam logic [1:0] I2SO_MODE_TDM = 2'b10;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/i2so_frame_buf.sv
// i2so_frame_buf: one-entry frame holding register behind the rts/rtr handshake
module i2so_frame_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rts,
  input  logic [W-1:0] data,
  input  logic         pop,
  output logic         rtr,
  output logic         valid,
  output logic [W-1:0] q
);
  logic take, valid_n;
  assign take = rts & rtr;
  assign valid_n = take | (valid & ~pop);
  // rtr is registered from the next occupancy, so it always equals ~valid outside reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      rtr <= 1'b0;
      q <= '0;
    end else begin
      valid <= valid_n;
      rtr <= ~valid_n;
      if (take) q <= data;
    end
  end
endmodule

// File: rtl/i2so_tdm_serializer.sv
// i2so_tdm_serializer: buffered multi-channel I2S/LJ/TDM serializer; I2SO_REPEAT_ON_UNDERRUN_EN replays the last frame on underrun
module i2so_tdm_serializer
  import i2so_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SLOT_W = 32,
  parameter int NUM_CH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sck_transition,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     filt_i2so_rts,
  input  logic [NUM_CH*DATA_W-1:0] filt_i2so_data,
  output logic                     filt_i2so_rtr,
  output logic                     i2so_sd,
  output logic                     i2so_ws,
  output logic                     i2so_underrun,
  output logic                     i2so_frame_start
);
  localparam int FRAME_BITS = NUM_CH * SLOT_W;
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] LAST = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] HALF = BW'(FRAME_BITS / 2);

  function automatic logic ws_of(input logic [1:0] m, input logic [BW-1:0] i);
    logic [BW-1:0] nx;
    nx = (i == LAST) ? '0 : i + 1'b1;
    return (m == I2SO_MODE_TDM) ? (i == LAST) : (m == I2SO_MODE_LJ) ? (i < HALF) : (nx >= HALF);
  endfunction

  state_t st, st_n;
  logic [BW-1:0] b, b_n;
  logic [FRAME_BITS-1:0] sr, sr_n, frame, fill, ld;
  logic [1:0] mode_q, mode_n;
  logic sd_n, ws_n, und_n, fs_n, start, pop, buf_valid;
  logic [NUM_CH*DATA_W-1:0] buf_data;

  i2so_frame_buf #(.W(NUM_CH * DATA_W)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .rts(filt_i2so_rts),
    .data(filt_i2so_data),
    .pop(pop),
    .rtr(filt_i2so_rtr),
    .valid(buf_valid),
    .q(buf_data)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
    assign frame[FRAME_BITS-1-c*SLOT_W -: SLOT_W] = SLOT_W'(buf_data[c*DATA_W +: DATA_W]) << (SLOT_W - DATA_W);
  end

`ifdef I2SO_REPEAT_ON_UNDERRUN_EN
  logic [FRAME_BITS-1:0] last_q;
  // Remember the last frame actually taken from the buffer so an underrun can replay it
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= '0;
    else if (pop) last_q <= frame;
  end
  assign fill = last_q;
`else
  assign fill = '0;
`endif

  // Next-state and output decode: frame starts, bit shifting and word-select generation
  always_comb begin
    start = sck_transition & en & (((st == ST_IDLE) & buf_valid) | ((st == ST_RUN) & (b == LAST)));
    pop = start & buf_valid;
    ld = buf_valid ? frame : fill;
    st_n = st;
    b_n = b;
    sr_n = sr;
    mode_n = mode_q;
    sd_n = i2so_sd;
    ws_n = i2so_ws;
    und_n = 1'b0;
    fs_n = 1'b0;
    if (start) begin
      st_n = ST_RUN;
      b_n = '0;
      sr_n = ld << 1;
      mode_n = mode;
      sd_n = ld[FRAME_BITS-1];
      ws_n = ws_of(mode, '0);
      und_n = ~buf_valid;
      fs_n = 1'b1;
    end else if (sck_transition && st == ST_RUN) begin
      st_n = (b == LAST) ? ST_IDLE : ST_RUN;
      b_n = (b == LAST) ? '0 : b + 1'b1;
      sr_n = sr << 1;
      sd_n = (b != LAST) & sr[FRAME_BITS-1];
      ws_n = (b != LAST) & ws_of(mode_q, b_n);
    end
  end

  // State and output registers; reset discards the in-flight frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= ST_IDLE;
      b <= '0;
      sr <= '0;
      mode_q <= I2SO_MODE_I2S;
      i2so_sd <= 1'b0;
      i2so_ws <= 1'b0;
      i2so_underrun <= 1'b0;
      i2so_frame_start <= 1'b0;
    end else begin
      st <= st_n;
      b <= b_n;
      sr <= sr_n;
      mode_q <= mode_n;
      i2so_sd <= sd_n;
      i2so_ws <= ws_n;
      i2so_underrun <= und_n;
      i2so_frame_start <= fs_n;
    end
  end
endmodule

// File: tb/tb_i2so_tdm_serializer.sv
// tb_i2so_tdm_serializer: randomized self-checking bench against a per-bit reference model
module tb_i2so_tdm_serializer;
  localparam int FB = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck = 1'b0;
  logic en = 1'b0;
  logic rts = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [31:0] din = '0;
  logic rtr, sd, ws, und, fs;
  int n_tests = 0;
  int n_fail = 0;

  i2so_tdm_serializer #(.DATA_W(16), .SLOT_W(32), .NUM_CH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sck_transition(sck),
    .en(en),
    .mode(mode),
    .filt_i2so_rts(rts),
    .filt_i2so_data(din),
    .filt_i2so_rtr(rtr),
    .i2so_sd(sd),
    .i2so_ws(ws),
    .i2so_underrun(und),
    .i2so_frame_start(fs)
  );

  always #5 clk = ~clk;

  // Bit k of a frame on the wire: slot k/32 carries channel k/32, sample MSB first, then zero padding
  function automatic logic exp_sd(input logic [31:0] fr, input int k);
    int c, s;
    c = k / 32;
    s = k % 32;
    return (s < 16) ? fr[c*16 + 15 - s] : 1'b0;
  endfunction

  function automatic logic exp_ws(input logic [1:0] m, input int k);
    if (m == 2'b10) return k == FB - 1;
    if (m == 2'b01) return k < FB / 2;
    return ((k + 1) % FB) >= FB / 2;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    en = 1'b0;
    sck = 1'b0;
    rts = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] d);
    int t;
    t = 0;
    while (rtr !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (rtr !== 1'b1) begin
      n_fail++;
      $display("FAIL push_rtr: rtr=%b, required 1", rtr);
    end
    rts = 1'b1;
    din = d;
    @(negedge clk);
    rts = 1'b0;
    n_tests++;
    if (rtr !== 1'b0) begin
      n_fail++;
      $display("FAIL push_full: rtr=%b, required 0", rtr);
    end
  endtask

  task automatic run_frame(input string nm, input logic [31:0] fr, input logic [1:0] m, input bit xund,
                           input int n, input int push_k, input logic [31:0] pd, input int drop_k);
    logic e_sd, e_ws, e_fs, e_und;
    for (int k = 0; k < n; k++) begin
      mode = (k == 0) ? m : 2'($urandom_range(0, 3));
      en = (drop_k < 0 || k < drop_k);
      sck = 1'b1;
      if (k == push_k) begin
        n_tests++;
        if (rtr !== 1'b1) begin
          n_fail++;
          $display("FAIL %s rtr_before_push k=%0d: got %b, required 1", nm, k, rtr);
        end
        rts = 1'b1;
        din = pd;
      end
      @(negedge clk);
      sck = 1'b0;
      rts = 1'b0;
      e_sd = exp_sd(fr, k);
      e_ws = exp_ws(m, k);
      e_fs = (k == 0);
      e_und = (k == 0) && xund;
      n_tests++;
      if (sd !== e_sd) begin
        n_fail++;
        $display("FAIL %s sd k=%0d: got %b, required %b", nm, k, sd, e_sd);
      end
      n_tests++;
      if (ws !== e_ws) begin
        n_fail++;
        $display("FAIL %s ws k=%0d mode=%0d: got %b, required %b", nm, k, m, ws, e_ws);
      end
      n_tests++;
      if (fs !== e_fs) begin
        n_fail++;
        $display("FAIL %s frame_start k=%0d: got %b, required %b", nm, k, fs, e_fs);
      end
      n_tests++;
      if (und !== e_und) begin
        n_fail++;
        $display("FAIL %s underrun k=%0d: got %b, required %b", nm, k, und, e_und);
      end
      @(negedge clk);
      if (k == 0) begin
        n_tests++;
        if ({fs, und} !== 2'b00) begin
          n_fail++;
          $display("FAIL %s pulse_width: fs/und=%b, required 00", nm, {fs, und});
        end
      end
    end
  endtask

  task automatic idle_tick(input string nm);
    sck = 1'b1;
    @(negedge clk);
    sck = 1'b0;
    n_tests++;
    if ({sd, ws, fs, und} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s idle sd/ws/fs/und: got %b, required 0000", nm, {sd, ws, fs, und});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    sck = 1'b1;
    repeat (3) @(negedge clk);
    sck = 1'b0;
    n_tests++;
    if ({sd, ws, und, fs, rtr} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset outputs sd/ws/und/fs/rtr: got %b, required 00000", {sd, ws, und, fs, rtr});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rtr !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release rtr: got %b, required 1", rtr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] f[5];
    logic [1:0] m[5];
    apply_reset();
    f[0] = 32'hCCCC_AAAA;
    m[0] = 2'b00;
    f[1] = 32'h0001_7398;
    m[1] = 2'b10;
    for (int i = 2; i < 5; i++) begin
      f[i] = $urandom;
      m[i] = 2'($urandom_range(0, 3));
    end
    en = 1'b1;
    push(f[0]);
    for (int i = 0; i < 5; i++)
      run_frame("stream", f[i], m[i], 1'b0, FB, (i < 4) ? 5 : -1, f[(i + 1) % 5], -1);
  endtask

  task automatic test_underrun();
    logic [31:0] a, rep;
    logic [1:0] m;
    apply_reset();
    a = $urandom;
    m = 2'($urandom_range(0, 2));
`ifdef I2SO_REPEAT_ON_UNDERRUN_EN
    rep = a;
`else
    rep = '0;
`endif
    en = 1'b1;
    push(a);
    run_frame("underrun_first", a, m, 1'b0, FB, -1, '0, -1);
    run_frame("underrun_1", rep, m, 1'b1, FB, -1, '0, -1);
    run_frame("underrun_2", rep, 2'b01, 1'b1, FB, -1, '0, -1);
  endtask

  task automatic test_same_edge();
    logic [31:0] a, b, rep;
    apply_reset();
    a = $urandom;
    b = $urandom;
`ifdef I2SO_REPEAT_ON_UNDERRUN_EN
    rep = a;
`else
    rep = '0;
`endif
    en = 1'b1;
    push(a);
    run_frame("same_edge_a", a, 2'b00, 1'b0, FB, -1, '0, -1);
    run_frame("same_edge_und", rep, 2'b10, 1'b1, FB, 0, b, -1);
    run_frame("same_edge_b", b, 2'b00, 1'b0, FB, -1, '0, -1);
  endtask

  task automatic test_en_drop();
    logic [31:0] a, b;
    apply_reset();
    a = $urandom;
    b = $urandom;
    en = 1'b1;
    push(a);
    run_frame("en_drop_a", a, 2'b01, 1'b0, FB, 5, b, 20);
    idle_tick("en_drop_wrap");
    idle_tick("en_drop_idle");
    n_tests++;
    if (rtr !== 1'b0) begin
      n_fail++;
      $display("FAIL en_drop buffered rtr: got %b, required 0", rtr);
    end
    run_frame("en_drop_b", b, 2'b00, 1'b0, FB, -1, '0, -1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b, c;
    apply_reset();
    a = $urandom;
    b = $urandom;
    c = $urandom;
    en = 1'b1;
    push(a);
    run_frame("reset_mid_a", a, 2'b00, 1'b0, 40, 5, b, -1);
    rst_n = 1'b0;
    sck = 1'b1;
    @(negedge clk);
    sck = 1'b0;
    n_tests++;
    if ({sd, ws, und, fs, rtr} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_mid outputs sd/ws/und/fs/rtr: got %b, required 00000", {sd, ws, und, fs, rtr});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rtr !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid release rtr: got %b, required 1", rtr);
    end
    repeat (3) idle_tick("reset_mid_stale");
    push(c);
    run_frame("reset_mid_c", c, 2'b10, 1'b0, FB, -1, '0, -1);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_underrun();
    test_same_edge();
    test_en_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/i2so_tdm_serializer.md
Name: i2so_tdm_serializer

Overview:
Parametrised successor to the two-channel I2S output serializer. It accepts whole multi-channel frames from the filter over the filt_i2so_rts/filt_i2so_rtr handshake, buffers one frame ahead, and shifts them out MSB-first on i2so_sd. i2so_ws is generated for I2S, left-justified or TDM framing, with a configurable slot width. It sits between the filter output stage and the I2S pins, timed by the existing one-cycle sck_transition pulse.

Parameters:
DATA_W, 16, sample width per channel in bits
SLOT_W, 32, bits per slot on the wire; must be >= DATA_W; LSBs below the sample are zero-padded
NUM_CH, 2, channels per frame; must be even and >= 2
FRAME_BITS, NUM_CH*SLOT_W, derived local constant, not overridable

Ports:
clk  in  1  system clock (only clock)
rst_n  in  1  synchronous, active-low reset
sck_transition  in  1  one-cycle bit-clock tick; every tick advances one bit
en  in  1  run enable
mode  in  2  00 I2S, 01 left-justified, 10 TDM, 11 reserved (treated as 00)
filt_i2so_rts  in  1  frame valid from filter
filt_i2so_data  in  NUM_CH*DATA_W  frame; channel 0 in bits [DATA_W-1:0]
filt_i2so_rtr  out  1  ready for a frame
i2so_sd  out  1  serial data
i2so_ws  out  1  word select / frame sync
i2so_underrun  out  1  one-cycle pulse: frame started with no frame buffered
i2so_frame_start  out  1  one-cycle pulse on the tick that drives the channel-0 MSB

Behaviour:
- Reset (rst_n low at clk edge): state IDLE, bit counter b=0, buffer empty, shift reg 0. Outputs: i2so_sd=0, i2so_ws=0, i2so_underrun=0, i2so_frame_start=0, filt_i2so_rtr=0. filt_i2so_rtr goes to 1 on the first cycle after reset is released. A reset mid-frame discards both the buffered and the in-flight frame.
- Handshake: a transfer occurs on any clk edge with filt_i2so_rts & filt_i2so_rtr. filt_i2so_rtr = ~buf_valid (registered), so the filter can have at most one frame pending. filt_i2so_data is sampled only on the transfer edge.
- States:
  - IDLE: sd=0, ws=0, b=0. Moves to RUN on a tick where en=1 and buf_valid=1.
  - RUN: active framing.
  - RUN -> IDLE only on the tick that would wrap b from FRAME_BITS-1 to 0 with en=0, so a frame always finishes. The wrap tick in that case drives sd=0, ws=0.
- Frame start tick (IDLE->RUN, or wrap in RUN with en=1):
  - mode is latched for the whole frame.
  - With buf_valid, the buffer moves into the shift reg and buf_valid clears. Each slot c is {data_c, (SLOT_W-DATA_W) zeros}, channel 0 first.
  - Without buf_valid, the shift reg is loaded with 0 and i2so_underrun pulses.
  - i2so_frame_start pulses on every frame start tick.
- No bypass: a frame accepted on the same edge as a frame start goes into the buffer. That start is an underrun, and the accepted frame plays next frame.
- Each RUN tick: the shift reg shifts left. i2so_sd takes the bit for b, registered on the tick edge, so it changes on the tick cycle. b increments modulo FRAME_BITS.
- i2so_ws for bit index b, updated on the same edge as sd:
  - I2S: ws = ((b+1) mod FRAME_BITS) >= FRAME_BITS/2. This leads data by one bit, and ws is low for the first half.
  - Left-justified: ws = (b < FRAME_BITS/2).
  - TDM: ws = (b == FRAME_BITS-1). This is a one-bit pulse one bit before the channel-0 MSB.
- Between ticks all outputs hold. A tick while rst_n is low is ignored.
- Widths: b is $clog2(FRAME_BITS) bits. No arithmetic on the data; samples are passed through bit-exact.

Optional Feature:
I2SO_REPEAT_ON_UNDERRUN_EN
- Defined: on an underrun the last successfully played frame is reloaded instead of zeros (zeros if none has played since reset). i2so_underrun still pulses.
- Undefined: the underrun frame is all zeros.

Decomposition:
- Package i2so_pkg holds:
  - mode encodings: I2SO_MODE_I2S, I2SO_MODE_LJ, I2SO_MODE_TDM
  - state encodings: ST_IDLE, ST_RUN
- Sub-module i2so_frame_buf: one-entry holding register with the rts/rtr handshake, buf_valid, and a pop input driven at frame start.

Test Plan:
- Default parameters, mode=00, ticks every 80 clk, frames L=16'hAAAA / R=16'hCCCC -> sd carries 1010... x16, then 16 zeros, then 1100... x16, then 16 zeros. ws low for bits 0..30 and high for bits 31..62; ws falls on bit 63. frame_start fires once per 64 ticks.
- mode=10, NUM_CH=4, SLOT_W=16, frame {16'h0001, 16'hFFFF, 16'hFF00, 16'h7398} (ch0 in the LSBs, so ch0=16'h7398 and ch3=16'h0001) -> ws is high only on bit 63. sd carries ch0..ch3 MSB-first: 7398, FF00, FFFF, 0001.
- filt_i2so_rts held low after the first frame -> second frame is all zeros, i2so_underrun pulses once per frame. With I2SO_REPEAT_ON_UNDERRUN_EN, the second frame repeats the first.
- Frame offered on the exact cycle of a frame-start tick with the buffer empty -> underrun pulse, and that frame plays in the following frame.
- en dropped at bit 20 -> the frame completes through bit 63, then the block enters IDLE with sd=0, ws=0. en raised with a buffered frame -> RUN starts on the next tick and frame_start pulses.
- rst_n low at bit 40 of a frame with the buffer full -> next cycle all outputs are 0 and filt_i2so_rtr=0. After release, filt_i2so_rtr=1 and no stale data is emitted.
